i2s_target: RTL

- I2S target (slave) endpoint. BCLK and LRCLK are driven by an external I2S controller, such as the team's own controller or a codec running as master.
- Block oversamples the bus with the system clock, deserialises stereo ADC words from sdata_in, and serialises stereo DAC words onto sdata_out.
- Sits between the pad ring and the audio datapath. Lets the design run as clock follower to a master codec.

---
 rtl/i2s_target.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/i2s_target.sv
// I2S target endpoint: follows external BCLK/LRCLK, deserialises stereo ADC words, serialises DAC words.
// Optional internal loopback (TX serial bit into RX shifter) when I2S_TARGET_LOOPBACK_EN is defined.
module i2s_target #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_W      = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i2s_bclk,
   input  logic                  i2s_lrclk,
   input  logic                  i2s_sdata_in,
`ifdef I2S_TARGET_LOOPBACK_EN
   input  logic                  lb_en,
`endif
   output logic                  i2s_sdata_out,
   input  logic [DATA_WIDTH-1:0] tx_left,
   input  logic [DATA_WIDTH-1:0] tx_right,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_left,
   output logic [DATA_WIDTH-1:0] rx_right,
   output logic                  rx_valid,
   output logic                  tx_underrun,
   output logic                  locked
);

   localparam logic [CNT_W-1:0] DW_C = CNT_W'(DATA_WIDTH);

   typedef enum logic {SYNC_WAIT = 1'b0, ACTIVE = 1'b1} state_t;
   state_t state_q, state_d;

   logic bclk_s1, bclk_s2, bclk_d;
   logic lr_s1, lr_s2, sd_s1, sd_s2, lr_prev;
   logic rise, fall, change, active, lose_sync, ev_left, ev_right;
   logic rx_bit, shift_en;

   logic [DATA_WIDTH-1:0] rx_shift, rx_shift_nxt, rx_word, left_stage;
   logic [CNT_W-1:0]      bit_cnt, cnt_nxt;
   logic                  have_left;

   logic [DATA_WIDTH-1:0] hold_l, hold_r, pair_r, tx_shift;
   logic [CNT_W-1:0]      tx_cnt;
   logic                  full, accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bclk_s1 <= 1'b0;
         bclk_s2 <= 1'b0;
         bclk_d  <= 1'b0;
         lr_s1   <= 1'b0;
         lr_s2   <= 1'b0;
         sd_s1   <= 1'b0;
         sd_s2   <= 1'b0;
         lr_prev <= 1'b0;
      end else begin
         bclk_s1 <= i2s_bclk;
         bclk_s2 <= bclk_s1;
         bclk_d  <= bclk_s2;
         lr_s1   <= i2s_lrclk;
         lr_s2   <= lr_s1;
         sd_s1   <= i2s_sdata_in;
         sd_s2   <= sd_s1;
         if (rise) lr_prev <= lr_s2;
      end
   end

   assign rise   = bclk_s2 & ~bclk_d;
   assign fall   = ~bclk_s2 & bclk_d;
   assign change = rise & (lr_s2 ^ lr_prev);
   assign active = (state_q == ACTIVE);
   // A slot shorter than two BCLKs means we are no longer aligned to the frame.
   assign lose_sync = active & change & (bit_cnt == '0);
   assign ev_left   = active & change & ~lr_s2 & ~lose_sync;
   assign ev_right  = active & change & lr_s2 & ~lose_sync;
   assign locked    = active;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= SYNC_WAIT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SYNC_WAIT: if (change & ~lr_s2) state_d = ACTIVE;
         ACTIVE:    if (lose_sync) state_d = SYNC_WAIT;
      endcase
   end

`ifdef I2S_TARGET_LOOPBACK_EN
   assign rx_bit = lb_en ? i2s_sdata_out : sd_s2;
`else
   assign rx_bit = sd_s2;
`endif

   assign shift_en     = (bit_cnt < DW_C);
   assign rx_shift_nxt = shift_en ? {rx_shift[DATA_WIDTH-2:0], rx_bit} : rx_shift;
   assign cnt_nxt      = shift_en ? bit_cnt + 1'b1 : bit_cnt;
   // Short slots leave the word right-aligned; shift it up so missing LSBs read as 0.
   assign rx_word      = rx_shift_nxt << (DW_C - cnt_nxt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_shift   <= '0;
         bit_cnt    <= '0;
         left_stage <= '0;
         have_left  <= 1'b0;
         rx_left    <= '0;
         rx_right   <= '0;
         rx_valid   <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (!active) begin
            rx_shift  <= '0;
            bit_cnt   <= '0;
            have_left <= 1'b0;
         end else if (rise) begin
            if (lose_sync) begin
               rx_shift  <= '0;
               bit_cnt   <= '0;
               have_left <= 1'b0;
            end else if (change) begin
               rx_shift <= '0;
               bit_cnt  <= '0;
               if (lr_s2) begin
                  left_stage <= rx_word;
                  have_left  <= 1'b1;
               end else if (have_left) begin
                  rx_left  <= left_stage;
                  rx_right <= rx_word;
                  rx_valid <= 1'b1;
               end
            end else begin
               rx_shift <= rx_shift_nxt;
               bit_cnt  <= cnt_nxt;
            end
         end
      end
   end

   // tx_valid/tx_ready: a pair transfers on a clk where both are high; the
   // offered pair must hold steady while tx_valid is high and tx_ready is low.
   assign tx_ready = ~full;
   assign accept   = tx_valid & ~full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_l        <= '0;
         hold_r        <= '0;
         full          <= 1'b0;
         pair_r        <= '0;
         tx_shift      <= '0;
         tx_cnt        <= '0;
         i2s_sdata_out <= 1'b0;
         tx_underrun   <= 1'b0;
      end else begin
         tx_underrun <= 1'b0;
         if (accept) begin
            hold_l <= tx_left;
            hold_r <= tx_right;
            full   <= 1'b1;
         end
         if (!active) begin
            pair_r   <= '0;
            tx_shift <= '0;
            tx_cnt   <= '0;
            if (fall) i2s_sdata_out <= 1'b0;
         end else if (ev_left) begin
            tx_cnt <= '0;
            if (full) begin
               tx_shift <= hold_l;
               pair_r   <= hold_r;
               full     <= 1'b0;
            end else begin
               tx_shift    <= '0;
               pair_r      <= '0;
               tx_underrun <= 1'b1;
            end
         end else if (ev_right) begin
            tx_shift <= pair_r;
            tx_cnt   <= '0;
         end else if (fall) begin
            // Output changes only on falls, so the previous LSB holds through the change rise.
            if (tx_cnt < DW_C) begin
               i2s_sdata_out <= tx_shift[DATA_WIDTH-1];
               tx_shift      <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
               tx_cnt        <= tx_cnt + 1'b1;
            end else begin
               i2s_sdata_out <= 1'b0;
            end
         end
      end
   end

endmodule
